tick_scheduler: RTL and testbench

Run-control and rate-configuration block for the design's time base. Replaces free-running derived clocks with single-cycle `tick` enables on the main clock, plus a 50% square output for display use. It sequences the divider through idle/run/pause, accepts new divide ratios through a valid/ready handshake, and supports periodic and one-shot operation. Game, timer and display logic consume `tick` as a clock enable.

---
 rtl/tick_pkg.sv | 12 +
 rtl/tick_counter.sv | 35 +++
 rtl/tick_scheduler.sv | 129 ++++++++++++
 tb/tb_tick_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared encodings for the tick scheduler: run-state values and the reset divide ratio.
package tick_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } tick_state_e;

    localparam int unsigned DEFAULT_DIV = 25000000;

endpackage

// File: rtl/tick_counter.sv
// Divider counter: counts enabled cycles and flags the terminal count (cnt == div-1).
module tick_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // div is never zero, so div-1 does not wrap
    assign tc = (cnt_q == div - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Run-control FSM and rate configuration producing single-cycle tick enables and a square output.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = tick_pkg::DEFAULT_DIV,
    parameter int unsigned TCNT_W      = 16
) (
    input  logic              CLKin,
    input  logic              clr_n,
    input  logic              cmd_start,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic              tick,
    output logic              sq_out,
    output logic              busy,
    output logic [1:0]        state,
    output logic [TCNT_W-1:0] tick_cnt
);

    tick_state_e       state_q, state_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic              oneshot_q, oneshot_d;
    logic              tick_q, tick_d;
    logic              sq_q, sq_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              cnt_clr, cnt_en, tc;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (CLKin),
        .rst_n (clr_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .div   (div_q),
        .tc    (tc)
    );

    assign cfg_ready = (state_q == StIdle);

    // A zero ratio would never reach terminal count; treat it as divide-by-one.
    always_comb begin
        div_d     = div_q;
        oneshot_d = oneshot_q;
        if (cfg_valid && cfg_ready) begin
            div_d     = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
            oneshot_d = cfg_oneshot;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        tick_d  = 1'b0;
        sq_d    = sq_q;
        tcnt_d  = tcnt_q;
        if (cmd_stop) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
            sq_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_start) begin
                        state_d = StRun;
                        cnt_clr = 1'b1;
                        tcnt_d  = '0;
                        sq_d    = 1'b0;
                    end
                end
                StRun: begin
                    if (cmd_pause) begin
                        state_d = StPause;
                    end else begin
                        cnt_en = 1'b1;
                        if (tc) begin
                            tick_d = 1'b1;
                            sq_d   = ~sq_q;
                            tcnt_d = tcnt_q + TCNT_W'(1);
                            if (oneshot_q) begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                StPause: begin
                    if (cmd_start) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLKin or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            div_q     <= CNT_W'(DEFAULT_DIV);
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign tick     = tick_q;
    assign sq_out   = sq_q;
    assign busy     = (state_q == StRun) || (state_q == StPause);
    assign state    = state_q;
    assign tick_cnt = tcnt_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a cycle model compared on every falling edge.
module tb_tick_scheduler;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DDIV   = 7;
    localparam int unsigned TCNT_W = 16;

    logic              CLKin = 1'b0;
    logic              clr_n;
    logic              cmd_start, cmd_pause, cmd_stop;
    logic              cfg_valid, cfg_ready, cfg_oneshot;
    logic [CNT_W-1:0]  cfg_div;
    logic              tick, sq_out, busy;
    logic [1:0]        state;
    logic [TCNT_W-1:0] tick_cnt;

    int nchecks = 0;
    int nerr    = 0;

    tick_scheduler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DDIV),
        .TCNT_W      (TCNT_W)
    ) dut (
        .CLKin       (CLKin),
        .clr_n       (clr_n),
        .cmd_start   (cmd_start),
        .cmd_pause   (cmd_pause),
        .cmd_stop    (cmd_stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .sq_out      (sq_out),
        .busy        (busy),
        .state       (state),
        .tick_cnt    (tick_cnt)
    );

    initial forever #5 CLKin = ~CLKin;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a tick fires on every RUN edge whose running count of counted edges is a multiple
    // of the ratio; pause edges are not counted.
    int     ms;
    longint mcounted, mdiv;
    bit     mone, msq, mtick;
    int     mtcnt;

    initial forever begin
        @(posedge CLKin or negedge clr_n);
        if (!clr_n) begin
            ms = 0; mcounted = 0; mdiv = DDIV; mone = 0; msq = 0; mtick = 0; mtcnt = 0;
        end else begin
            automatic bit idle_before = (ms == 0);
            mtick = 0;
            if (cmd_stop) begin
                ms = 0; mcounted = 0; msq = 0;
            end else if (ms == 1) begin
                if (cmd_pause) begin
                    ms = 2;
                end else begin
                    mcounted++;
                    if (mcounted % mdiv == 0) begin
                        mtick = 1;
                        msq   = ~msq;
                        mtcnt = (mtcnt + 1) % (1 << TCNT_W);
                        if (mone) ms = 0;
                    end
                end
            end else if (ms == 2) begin
                if (cmd_start) ms = 1;
            end else if (cmd_start) begin
                ms = 1; mcounted = 0; mtcnt = 0; msq = 0;
            end
            if (idle_before && cfg_valid) begin
                mdiv = (cfg_div == 0) ? 1 : longint'(cfg_div);
                mone = cfg_oneshot;
            end
        end
    end

    always @(negedge CLKin) begin
        chk("state", 64'(state), 64'(ms));
        chk("cfg_ready", 64'(cfg_ready), 64'(ms == 0));
        chk("busy", 64'(busy), 64'(ms != 0));
        chk("tick", 64'(tick), 64'(mtick));
        chk("sq_out", 64'(sq_out), 64'(msq));
        chk("tick_cnt", 64'(tick_cnt), 64'(mtcnt));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLKin);
    endtask

    task automatic stop_pulse();
        cmd_stop = 1'b1;
        cyc(1);
        cmd_stop = 1'b0;
    endtask

    initial begin
        clr_n = 1'b0; cmd_start = 0; cmd_pause = 0; cmd_stop = 0;
        cfg_valid = 0; cfg_div = '0; cfg_oneshot = 0;
        cyc(3);
        clr_n = 1'b1;

        // Idle after reset
        cyc(100);
        chk("idle_state", 64'(state), 0);
        chk("idle_ready", 64'(cfg_ready), 1);

        // Periodic D=4, config and start in the same cycle
        cfg_valid = 1; cfg_div = 4; cfg_oneshot = 0; cmd_start = 1;
        cyc(1); cfg_valid = 0; cmd_start = 0;
        cyc(3); chk("p4_no_tick_e3", 64'(tick), 0);
        cyc(1); chk("p4_tick_e4", 64'(tick), 1); chk("p4_sq_e4", 64'(sq_out), 1);
        cyc(4); chk("p4_tick_e8", 64'(tick), 1); chk("p4_sq_e8", 64'(sq_out), 0);
        cyc(4); chk("p4_tick_e12", 64'(tick), 1); chk("p4_cnt_e12", 64'(tick_cnt), 3);
        stop_pulse();
        chk("stop_holds_cnt", 64'(tick_cnt), 3); chk("stop_sq", 64'(sq_out), 0);

        // D=5 with pause E3..E11, resume at E12, config offered while paused
        cfg_valid = 1; cfg_div = 5; cmd_start = 1;
        cyc(1); cfg_valid = 0; cmd_start = 0;
        cyc(2); cmd_pause = 1; cfg_valid = 1; cfg_div = 9;
        cyc(2); chk("pause_ready", 64'(cfg_ready), 0); chk("pause_state", 64'(state), 2);
        cyc(7); cmd_pause = 0; cmd_start = 1; cfg_valid = 0;
        cyc(1); cmd_start = 0;
        cyc(2); chk("pause_no_tick_e14", 64'(tick), 0);
        cyc(1); chk("pause_tick_e15", 64'(tick), 1); chk("pause_cnt", 64'(tick_cnt), 1);
        stop_pulse();

        // One-shot with zero ratio
        cfg_valid = 1; cfg_div = 0; cfg_oneshot = 1; cmd_start = 1;
        cyc(1); cfg_valid = 0; cmd_start = 0;
        chk("os_busy_e0", 64'(busy), 1);
        cyc(1); chk("os_tick_e1", 64'(tick), 1); chk("os_idle_e1", 64'(state), 0);
        chk("os_busy_e1", 64'(busy), 0); chk("os_cnt_e1", 64'(tick_cnt), 1);
        cyc(1); chk("os_no_tick_e2", 64'(tick), 0);
        cfg_valid = 1; cfg_div = 3; cfg_oneshot = 0;
        cyc(1); cfg_valid = 0;

        // Stop+pause+start on the terminal-count edge, then start+pause from idle
        cmd_start = 1;
        cyc(1); cmd_start = 0;
        cyc(2); cmd_start = 1; cmd_pause = 1; cmd_stop = 1;
        cyc(1); chk("all_cmd_state", 64'(state), 0); chk("all_cmd_tick", 64'(tick), 0);
        cmd_stop = 0;
        cyc(1); chk("start_pause_idle", 64'(state), 1);
        cmd_start = 0; cmd_pause = 0;
        stop_pulse();

        // Async reset mid-run, then default ratio governs
        cmd_start = 1;
        cyc(1); cmd_start = 0;
        cyc(4); chk("pre_rst_cnt", 64'(tick_cnt), 1);
        #2 clr_n = 1'b0;
        #1;
        chk("rst_state", 64'(state), 0); chk("rst_tick_cnt", 64'(tick_cnt), 0);
        chk("rst_sq", 64'(sq_out), 0); chk("rst_ready", 64'(cfg_ready), 1);
        cyc(1); clr_n = 1'b1;
        cyc(1); cmd_start = 1;
        cyc(1); cmd_start = 0;
        cyc(6); chk("dflt_no_tick_e6", 64'(tick), 0);
        cyc(1); chk("dflt_tick_e7", 64'(tick), 1);
        stop_pulse();

        // tick_cnt wrap at D=1
        cfg_valid = 1; cfg_div = 0; cfg_oneshot = 0; cmd_start = 1;
        cyc(1); cfg_valid = 0; cmd_start = 0;
        cyc(65535); chk("wrap_pre", 64'(tick_cnt), 65535);
        cyc(1); chk("wrap_zero", 64'(tick_cnt), 0); chk("wrap_tick", 64'(tick), 1);
        stop_pulse();
        cyc(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
